// File: rtl/operand_sequencer_pkg.sv
// Operand sequencer shared types and constants.
// States, opcode classes and RV32 field positions.
package operand_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_READ        = 3'd1,
    S_CAPTURE     = 3'd2,
    S_ISSUE       = 3'd3,
    S_WAIT_RESULT = 3'd4,
    S_WRITEBACK   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;

  // Stores and branches carry immediate bits in the rd slot.
  function automatic logic opc_has_rd(input logic [6:0] opc);
    return !((opc == OPC_STORE) || (opc == OPC_BRANCH));
  endfunction

endpackage

// File: rtl/operand_sequencer_instr_field_decode.sv
// Combinational RV32 field extraction for the sequencer.
// Yields register indices and whether rd is written.
module instr_field_decode
  import operand_sequencer_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic        o_has_rd
);

  logic [6:0] w_opcode;
  logic       w_unused;

  assign w_opcode = i_instr[OPC_MSB:OPC_LSB];
  assign o_rs1    = i_instr[RS1_MSB:RS1_LSB];
  assign o_rs2    = i_instr[RS2_MSB:RS2_LSB];
  assign o_rd     = i_instr[RD_MSB:RD_LSB];
  assign o_has_rd = opc_has_rd(w_opcode);

  assign w_unused = ^{i_instr[31:25], i_instr[14:12]};

endmodule

// File: rtl/operand_sequencer.sv
// Single-issue operand sequencer: RF read, issue to execute,
// wait for the result and write it back. No overlap between instrs.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int RF_READ_LATENCY   = 1,
  parameter int SUPPRESS_X0_WRITE = 1
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  output logic [4:0]  rf_rd_addr,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  output logic        rf_write_enable,
  output logic [31:0] rf_write_data,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [4:0]  op_rd,
  input  logic        result_valid,
  output logic        result_ready,
  input  logic [31:0] result_data,
  output logic        busy
);

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic        r_has_rd;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic        r_op_valid;
  logic        r_result_ready;
  logic        r_wr_en;
  logic [31:0] r_wr_data;
  logic        r_instr_ready;
  logic        r_busy;

  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic        w_has_rd;
  logic        w_accept;
  logic        w_read_done;
  logic        w_do_write;

  instr_field_decode u_dec (
    .i_instr  (instr),
    .o_rs1    (w_rs1),
    .o_rs2    (w_rs2),
    .o_rd     (w_rd),
    .o_has_rd (w_has_rd)
  );

  assign w_accept    = instr_valid && r_instr_ready;
  assign w_read_done = (r_cnt == 2'(RF_READ_LATENCY - 1));
  assign w_do_write  = r_has_rd &&
                       !((SUPPRESS_X0_WRITE != 0) && (r_rd == 5'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_rd           <= '0;
      r_has_rd       <= 1'b0;
      r_op_a         <= '0;
      r_op_b         <= '0;
      r_op_valid     <= 1'b0;
      r_result_ready <= 1'b0;
      r_wr_en        <= 1'b0;
      r_wr_data      <= '0;
      r_instr_ready  <= 1'b1;
      r_busy         <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rs1         <= w_rs1;
            r_rs2         <= w_rs2;
            r_rd          <= w_rd;
            r_has_rd      <= w_has_rd;
            r_cnt         <= '0;
            r_instr_ready <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= S_READ;
          end
        end
        S_READ: begin
          if (w_read_done) begin
            r_state <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_CAPTURE: begin
          r_op_a     <= rf_rs1_data;
          r_op_b     <= rf_rs2_data;
          r_op_valid <= 1'b1;
          r_state    <= S_ISSUE;
        end
        S_ISSUE: begin
          if (op_ready) begin
            r_op_valid     <= 1'b0;
            r_result_ready <= 1'b1;
            r_state        <= S_WAIT_RESULT;
          end
        end
        S_WAIT_RESULT: begin
          if (result_valid) begin
            r_wr_data      <= result_data;
            r_result_ready <= 1'b0;
            if (w_do_write) begin
              r_wr_en <= 1'b1;
              r_state <= S_WRITEBACK;
            end else begin
              r_instr_ready <= 1'b1;
              r_busy        <= 1'b0;
              r_state       <= S_IDLE;
            end
          end
        end
        S_WRITEBACK: begin
          r_wr_en       <= 1'b0;
          r_instr_ready <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready     = r_instr_ready;
  assign busy            = r_busy;
  assign rf_rs1_addr     = r_rs1;
  assign rf_rs2_addr     = r_rs2;
  assign rf_rd_addr      = r_rd;
  assign op_rd           = r_rd;
  assign op_a            = r_op_a;
  assign op_b            = r_op_b;
  assign op_valid        = r_op_valid;
  assign result_ready    = r_result_ready;
  assign rf_write_enable = r_wr_en;
  assign rf_write_data   = r_wr_data;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer at read latency 1 and 2.
// Register file model writes on negedge, reads on posedge.
module tb_operand_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        instr_valid, instr_ready;
  logic [31:0] instr;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        we;
  logic [31:0] wdata;
  logic        op_valid, op_ready;
  logic [31:0] op_a, op_b;
  logic [4:0]  op_rd;
  logic        result_valid, result_ready;
  logic [31:0] result_data;
  logic        busy;

  logic        instr_valid_2, instr_ready_2;
  logic [31:0] instr_2;
  logic [4:0]  rs1_addr_2, rs2_addr_2, rd_addr_2;
  logic [31:0] rs1_data_2, rs2_data_2;
  logic        we_2;
  logic [31:0] wdata_2;
  logic        op_valid_2, op_ready_2;
  logic [31:0] op_a_2, op_b_2;
  logic [4:0]  op_rd_2;
  logic        result_valid_2, result_ready_2;
  logic [31:0] result_data_2;
  logic        busy_2;

  operand_sequencer #(
    .RF_READ_LATENCY(1), .SUPPRESS_X0_WRITE(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_rs1_addr(rs1_addr), .rf_rs2_addr(rs2_addr), .rf_rd_addr(rd_addr),
    .rf_rs1_data(rs1_data), .rf_rs2_data(rs2_data),
    .rf_write_enable(we), .rf_write_data(wdata),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_data(result_data), .busy(busy)
  );

  operand_sequencer #(
    .RF_READ_LATENCY(2), .SUPPRESS_X0_WRITE(1)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid_2), .instr_ready(instr_ready_2), .instr(instr_2),
    .rf_rs1_addr(rs1_addr_2), .rf_rs2_addr(rs2_addr_2), .rf_rd_addr(rd_addr_2),
    .rf_rs1_data(rs1_data_2), .rf_rs2_data(rs2_data_2),
    .rf_write_enable(we_2), .rf_write_data(wdata_2),
    .op_valid(op_valid_2), .op_ready(op_ready_2),
    .op_a(op_a_2), .op_b(op_b_2), .op_rd(op_rd_2),
    .result_valid(result_valid_2), .result_ready(result_ready_2),
    .result_data(result_data_2), .busy(busy_2)
  );

  logic [31:0] rf [32];
  logic        rf_loaded = 1'b0;
  logic [31:0] p2_a, p2_b;
  int          we_pulses = 0;

  function automatic logic [31:0] rdrf(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : rf[a];
  endfunction

  always @(negedge clk) begin
    if (!rf_loaded) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      rf[5] <= 32'h11;
      rf[6] <= 32'h22;
      rf_loaded <= 1'b1;
    end else begin
      if (we) rf[rd_addr] <= wdata;
      if (we_2) rf[rd_addr_2] <= wdata_2;
    end
  end

  always @(posedge clk) begin
    rs1_data   <= rdrf(rs1_addr);
    rs2_data   <= rdrf(rs2_addr);
    p2_a       <= rdrf(rs1_addr_2);
    p2_b       <= rdrf(rs2_addr_2);
    rs1_data_2 <= p2_a;
    rs2_data_2 <= p2_b;
    if (we) we_pulses <= we_pulses + 1;
  end

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [31:0] ins,
                       input logic [31:0] ea, input logic [31:0] eb,
                       input logic [4:0] erd, input logic [31:0] res,
                       input logic ewb);
    chk({tag, "_rdy"}, instr_ready, 1);
    instr_valid = 1'b1;
    instr = ins;
    tick();
    instr_valid = 1'b0;
    tick();
    chk({tag, "_nov"}, op_valid, 0);
    tick();
    chk({tag, "_ov"}, op_valid, 1);
    chk({tag, "_a"}, op_a, ea);
    chk({tag, "_b"}, op_b, eb);
    chk({tag, "_rd"}, op_rd, erd);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    chk({tag, "_rr"}, result_ready, 1);
    result_valid = 1'b1;
    result_data = res;
    tick();
    result_valid = 1'b0;
    chk({tag, "_we"}, we, ewb);
    if (ewb) begin
      chk({tag, "_wd"}, wdata, res);
      chk({tag, "_wa"}, rd_addr, erd);
      tick();
      chk({tag, "_we0"}, we, 0);
    end
    chk({tag, "_idle"}, instr_ready, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int wp;
    instr_valid = 0; instr = '0; op_ready = 0;
    result_valid = 0; result_data = '0;
    instr_valid_2 = 0; instr_2 = '0; op_ready_2 = 0;
    result_valid_2 = 0; result_data_2 = '0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_irdy", instr_ready, 1);
    chk("rst_ov", op_valid, 0);
    chk("rst_we", we, 0);
    chk("rst_rr", result_ready, 0);
    chk("rst_opa", op_a, 0);
    chk("rst_wd", wdata, 0);
    chk("rst_rs1", rs1_addr, 0);
    tick(); tick(); tick();
    rst_n = 1'b1;

    // add x7,x5,x6 with a stalled execute stage
    instr_valid = 1'b1;
    instr = 32'h006283B3;
    tick();
    instr_valid = 1'b0;
    chk("a_busy", busy, 1);
    chk("a_irdy", instr_ready, 0);
    chk("a_rs1", rs1_addr, 5);
    chk("a_rs2", rs2_addr, 6);
    chk("a_rd", rd_addr, 7);
    tick();
    chk("a_nov", op_valid, 0);
    tick();
    chk("a_ov", op_valid, 1);
    chk("a_opa", op_a, 32'h11);
    chk("a_opb", op_b, 32'h22);
    chk("a_oprd", op_rd, 7);
    instr_valid = 1'b1;
    instr = 32'h00538433;
    result_valid = 1'b1;
    result_data = 32'h00000BAD;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_ov", op_valid, 1);
      chk("hold_a", op_a, 32'h11);
      chk("hold_b", op_b, 32'h22);
      chk("hold_irdy", instr_ready, 0);
      chk("hold_rr", result_ready, 0);
    end
    instr_valid = 1'b0;
    result_valid = 1'b0;
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    chk("a_ov0", op_valid, 0);
    chk("a_rr", result_ready, 1);
    result_valid = 1'b1;
    result_data = 32'h33;
    tick();
    result_valid = 1'b0;
    chk("a_we", we, 1);
    chk("a_wd", wdata, 32'h33);
    chk("a_wa", rd_addr, 7);
    chk("a_rr0", result_ready, 0);
    tick();
    chk("a_we0", we, 0);
    chk("a_irdy1", instr_ready, 1);
    chk("a_x7", rf[7], 32'h33);

    // rd = x0: no write strobe at all
    wp = we_pulses;
    do_op("x0", 32'h00628033, 32'h11, 32'h22, 5'd0, 32'hDEAD, 1'b0);
    tick();
    chk("x0_pulses", we_pulses, wp);

    // stores never write back
    do_op("sw0", 32'h0062A023, 32'h11, 32'h22, 5'd0, 32'h1234, 1'b0);
    do_op("sw4", 32'h0062A223, 32'h11, 32'h22, 5'd4, 32'h5678, 1'b0);
    chk("sw_pulses", we_pulses, wp);
    chk("sw_x4", rf[4], 0);

    // add x8,x7,x5 reads back the earlier writeback
    do_op("dep", 32'h00538433, 32'h33, 32'h11, 5'd8, 32'h44, 1'b1);
    tick();
    chk("dep_x8", rf[8], 32'h44);

    // reset in the middle of a writeback cycle
    instr_valid = 1'b1;
    instr = 32'h006284B3;
    tick();
    instr_valid = 1'b0;
    tick(); tick();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    result_valid = 1'b1;
    result_data = 32'h99;
    tick();
    result_valid = 1'b0;
    chk("wbr_we1", we, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("wbr_we0", we, 0);
    chk("wbr_busy", busy, 0);
    chk("wbr_irdy", instr_ready, 1);
    #3;
    chk("wbr_x9", rf[9], 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("wbr_x9b", rf[9], 0);
    chk("post_busy", busy, 0);

    // read latency 2 instance
    instr_valid_2 = 1'b1;
    instr_2 = 32'h006283B3;
    tick();
    instr_valid_2 = 1'b0;
    chk("l2_busy", busy_2, 1);
    tick();
    chk("l2_nov1", op_valid_2, 0);
    tick();
    chk("l2_nov2", op_valid_2, 0);
    tick();
    chk("l2_ov", op_valid_2, 1);
    chk("l2_a", op_a_2, 32'h11);
    chk("l2_b", op_b_2, 32'h22);
    chk("l2_rd", op_rd_2, 7);
    op_ready_2 = 1'b1;
    tick();
    op_ready_2 = 1'b0;
    result_valid_2 = 1'b1;
    result_data_2 = 32'h55;
    tick();
    result_valid_2 = 1'b0;
    chk("l2_we", we_2, 1);
    chk("l2_wd", wdata_2, 32'h55);
    tick();
    chk("l2_we0", we_2, 0);
    chk("l2_x7", rf[7], 32'h55);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter RF_READ_LATENCY, default 1, cycles from register-file address to valid read data (legal values 1 or 2).
REQ-002 SHALL have parameter SUPPRESS_X0_WRITE, default 1; 1 means never assert rf_write_enable for rd=0.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port instr_valid, input, 1, instruction word offered.
REQ-006 SHALL have port instr_ready, output, 1, sequencer accepts instruction.
REQ-007 SHALL have port instr, input, 32, RV32 instruction word.
REQ-008 SHALL have ports rf_rs1_addr, rf_rs2_addr and rf_rd_addr, output, 5 each, register-file addresses.
REQ-009 SHALL have ports rf_rs1_data and rf_rs2_data, input, 32 each, register-file read data.
REQ-010 SHALL have port rf_write_enable, output, 1, register-file write strobe; port rf_write_data, output, 32.
REQ-011 SHALL have ports op_valid (output, 1), op_ready (input, 1), op_a and op_b (output, 32 each), op_rd (output, 5): operand bundle to execute stage.
REQ-012 SHALL have ports result_valid (input, 1), result_ready (output, 1), result_data (input, 32): result from execute stage.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, READ, CAPTURE, ISSUE, WAIT_RESULT, WRITEBACK.
REQ-015 IDLE: instr_ready=1; a transfer occurs when instr_valid&&instr_ready; latch rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], opcode=instr[6:0]; go to READ.
REQ-016 READ: drive latched addresses on rf_rs1_addr, rf_rs2_addr and rf_rd_addr; hold for RF_READ_LATENCY cycles; then go to CAPTURE.
REQ-017 CAPTURE: register rf_rs1_data into op_a and rf_rs2_data into op_b; go to ISSUE the next cycle.
REQ-018 ISSUE: op_valid=1; op_a, op_b and op_rd stay stable until op_ready; on op_valid&&op_ready go to WAIT_RESULT.
REQ-019 WAIT_RESULT: result_ready=1; on result_valid, latch result_data into rf_write_data.
REQ-020 A result SHALL set has_rd unless the opcode is store (0100011) or branch (1100011).
REQ-021 If has_rd and not (SUPPRESS_X0_WRITE and rd=0), the next state SHALL be WRITEBACK, else IDLE.
REQ-022 WRITEBACK: rf_write_enable=1 for exactly one full cycle, with rf_rd_addr and rf_write_data stable across that cycle, because the file samples on negedge; then return to IDLE.
REQ-023 rf_write_enable SHALL be 0 in every state except WRITEBACK.
REQ-024 instr_ready SHALL be 0 outside IDLE; no new instruction is accepted until return to IDLE, giving no overlap and no hazard logic.
REQ-025 result_valid outside WAIT_RESULT SHALL be ignored; op_ready outside ISSUE SHALL be ignored.
REQ-026 Best-case latency SHALL be accept to op_valid = RF_READ_LATENCY+2 cycles; result to write strobe = 1 cycle.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE.
REQ-028 Reset SHALL zero all outputs except instr_ready, which is 1 once in IDLE.
REQ-029 Reset mid-WRITEBACK SHALL drop rf_write_enable immediately, and the write is lost.
REQ-030 After rst_n deasserts, the first accept SHALL occur no earlier than the next posedge.

Structure
REQ-031 Shared package SHALL hold: the state enum; opcode constants OPC_STORE and OPC_BRANCH; the instruction field bit-position constants.
REQ-032 A single sub-module, instr_field_decode (combinational: rs1, rs2, rd, has_rd from instr), SHALL be used.

Verification
REQ-033 Preload x5=0x11, x6=0x22; send add x7,x5,x6 (0x006283B3) -> op_a=0x11, op_b=0x22, op_rd=7 on ISSUE; result 0x33 -> one-cycle write x7=0x33.
REQ-034 Send an instruction with rd=0 and result 0xDEAD -> rf_write_enable never asserts; instr_ready returns the cycle after the result.
REQ-035 Send store sw x6,0(x5) (0x0062A023) -> no WRITEBACK state, no write.
REQ-036 Hold op_ready=0 for 5 cycles -> op_valid, op_a and op_b stable throughout; instr_ready=0 while a second instr_valid is held.
REQ-037 Assert rst_n low during WRITEBACK -> rf_write_enable=0 and busy=0 asynchronously; the register is unchanged.
REQ-038 Run with RF_READ_LATENCY=2 -> op_valid rises 4 cycles after accept, with correct operands.
